// File: rtl/mc_pkg.sv
// mc_pkg: FSM states and the address-window test shared by the
// request sequencer and memory_controller.
package mc_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, RD_CAPTURE, RESP} state_t;

    localparam int RESP_FLAG_W = 1;

    // Operands are widened to 33 bits so base + window size cannot overflow.
    function automatic logic addr_in_window(input logic [32:0] addr, input logic [32:0] base,
                                            input int abits);
        return (addr >= base) && (addr < base + (33'd1 << abits));
    endfunction

endpackage

// File: rtl/mem_req_fifo.sv
// mem_req_fifo: synchronous request FIFO with show-ahead head and occupancy count.
module mem_req_fifo #(
    parameter int WIDTH = 25,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp, rp;
    logic             do_push, do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rp];

    always_ff @(posedge clk)
        if (do_push) mem[wp] <= wdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            wp    <= do_push ? wp + PW'(1) : wp;
            rp    <= do_pop ? rp + PW'(1) : rp;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: queues CPU read/write requests and issues them one at a
// time to memory_controller, returning one in-order response per request.
module mem_req_sequencer
    import mc_pkg::*;
#(
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = 16,
    parameter logic [ADDR_WIDTH-1:0] MEM_BASE_ADDR  = 16'h1000,
    parameter int                    MEM_ADDR_BITS  = 11,
    parameter int                    FIFO_DEPTH     = 4,
    parameter int                    TIMEOUT_CYCLES = 15
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic                            req_write,
    input  logic [ADDR_WIDTH-1:0]           req_addr,
    input  logic [DATA_WIDTH-1:0]           req_wdata,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_write,
    output logic                            resp_err,
    output logic [DATA_WIDTH-1:0]           resp_rdata,
    output logic [ADDR_WIDTH-1:0]           cpu_addr,
    output logic [DATA_WIDTH-1:0]           cpu_write_data,
    output logic                            cpu_read_en,
    output logic                            cpu_write_en,
    input  logic [DATA_WIDTH-1:0]           cpu_read_data,
    input  logic                            cpu_ready,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
    localparam int FW = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    state_t                 state, state_n;
    logic [TW-1:0]          tcnt, tcnt_n;
    logic [FW-1:0]          head;
    logic                   h_write, h_in_win, empty, full, pop, slot_free;
    logic [ADDR_WIDTH-1:0]  h_addr, cpu_addr_n;
    logic [DATA_WIDTH-1:0]  h_data, cpu_wdata_n, rdata_n;
    logic                   rd_en_n, wr_en_n, rv_n, rw_n, re_n;

    assign {h_write, h_addr, h_data} = head;
    assign req_ready = !full;
    assign slot_free = !resp_valid || resp_ready;
    assign h_in_win  = addr_in_window(33'(h_addr), 33'(MEM_BASE_ADDR), MEM_ADDR_BITS);

    mem_req_fifo #(.WIDTH(FW), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (req_valid && req_ready),
        .wdata   ({req_write, req_addr, req_wdata}),
        .pop     (pop),
        .rdata   (head),
        .count   (fifo_count),
        .full    (full),
        .empty   (empty)
    );

    always_comb begin
        state_n     = state;
        tcnt_n      = tcnt;
        pop         = 1'b0;
        cpu_addr_n  = cpu_addr;
        cpu_wdata_n = cpu_write_data;
        rd_en_n     = cpu_read_en;
        wr_en_n     = cpu_write_en;
        rv_n        = resp_valid && !resp_ready;
        rw_n        = resp_write;
        re_n        = resp_err;
        rdata_n     = resp_rdata;
        case (state)
            IDLE: if (!empty && slot_free) begin
                pop     = 1'b1;
                rw_n    = h_write;
                re_n    = !h_in_win;
                rdata_n = '0;
                if (h_in_win) begin
                    cpu_addr_n  = h_addr;
                    cpu_wdata_n = h_data;
                    wr_en_n     = h_write;
                    rd_en_n     = !h_write;
                    tcnt_n      = '0;
                    state_n     = ISSUE;
                end else begin
                    state_n = RESP;
                end
            end
            // Response fields are staged here; resp_valid rises one state later.
            ISSUE: if (cpu_ready || tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                rd_en_n = 1'b0;
                wr_en_n = 1'b0;
                rw_n    = cpu_write_en;
                re_n    = !cpu_ready;
                rdata_n = '0;
                state_n = (cpu_ready && cpu_read_en) ? RD_CAPTURE : RESP;
            end else begin
                tcnt_n = tcnt + TW'(1);
            end
            RD_CAPTURE: begin
                rdata_n = cpu_read_data;
                rv_n    = 1'b1;
                state_n = IDLE;
            end
            default: begin
                rv_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            tcnt           <= '0;
            cpu_addr       <= '0;
            cpu_write_data <= '0;
            cpu_read_en    <= 1'b0;
            cpu_write_en   <= 1'b0;
            resp_valid     <= 1'b0;
            resp_write     <= 1'b0;
            resp_err       <= 1'b0;
            resp_rdata     <= '0;
        end else begin
            state          <= state_n;
            tcnt           <= tcnt_n;
            cpu_addr       <= cpu_addr_n;
            cpu_write_data <= cpu_wdata_n;
            cpu_read_en    <= rd_en_n;
            cpu_write_en   <= wr_en_n;
            resp_valid     <= rv_n;
            resp_write     <= rw_n;
            resp_err       <= re_n;
            resp_rdata     <= rdata_n;
        end
    end

endmodule

// File: tb/tb_mem_req_sequencer.sv
// tb_mem_req_sequencer: sequencer against a behavioural controller/SRAM, with a
// transaction-level response model, a vector table and hand-written corner cases.
module tb_mem_req_sequencer;
    localparam int BASE = 'h1000;
    localparam int BITS = 11;
    localparam int TO   = 15;

    logic        clk = 0, reset_n;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid, resp_ready, resp_write, resp_err;
    logic [7:0]  resp_rdata;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_write_data, cpu_read_data;
    logic        cpu_read_en, cpu_write_en, cpu_ready;
    logic [2:0]  fifo_count;

    logic rr_mode = 0, rr_fixed = 1, rr_rand = 1;
    assign resp_ready = rr_mode ? rr_rand : rr_fixed;

    mem_req_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_err(resp_err), .resp_rdata(resp_rdata),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
        .cpu_read_data(cpu_read_data), .cpu_ready(cpu_ready),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    // Controller stand-in: ready after a configurable number of wait cycles, read data registered.
    int         wr_ws = 0, rd_ws = 0, wcnt = 0;
    bit         stub = 0;
    logic [7:0] sram [2048];
    logic [7:0] ref_mem [2048];
    assign cpu_ready = !stub && ((cpu_write_en && wcnt == wr_ws) || (cpu_read_en && wcnt == rd_ws));

    always @(posedge clk) begin
        wcnt <= ((cpu_read_en || cpu_write_en) && !cpu_ready) ? wcnt + 1 : 0;
        if (cpu_write_en && cpu_ready) sram[cpu_addr[10:0]] <= cpu_write_data;
        if (cpu_read_en && cpu_ready) cpu_read_data <= sram[cpu_addr[10:0]];
    end

    always @(negedge clk) rr_rand <= 1'($urandom_range(0, 1));

    int checks = 0, failures = 0, nresp = 0, wr_hi = 0, rd_hi = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    typedef struct { logic w; logic e; logic [7:0] d; } resp_t;
    resp_t expq [$];

    function automatic resp_t model(input logic w, input logic [15:0] a, input logic [7:0] d);
        resp_t r;
        bit inw = int'(a) >= BASE && int'(a) < BASE + (1 << BITS);
        r.w = w; r.e = !inw || stub; r.d = 8'h00;
        if (inw && !stub) begin
            if (w) ref_mem[int'(a) - BASE] = d;
            else   r.d = ref_mem[int'(a) - BASE];
        end
        return r;
    endfunction

    always @(posedge clk) begin
        wr_hi += int'(cpu_write_en);
        rd_hi += int'(cpu_read_en);
        if (!reset_n) expq.delete();
        else begin
            if (resp_valid && resp_ready) begin
                resp_t e;
                nresp++;
                if (expq.size() == 0) chk("resp_unexpected", 1, 0);
                else begin
                    e = expq.pop_front();
                    chk("mon_write", resp_write, e.w);
                    chk("mon_err", resp_err, e.e);
                    chk("mon_rdata", resp_rdata, e.d);
                end
            end
            if (req_valid && req_ready) expq.push_back(model(req_write, req_addr, req_wdata));
        end
    end

    task automatic send(input logic w, input logic [15:0] a, input logic [7:0] d);
        int n = 0;
        @(negedge clk);
        req_valid = 1; req_write = w; req_addr = a; req_wdata = d;
        while (!req_ready && n < 200) begin @(negedge clk); n++; end
        if (!req_ready) chk("send_timeout", 0, 1);
        @(negedge clk);
        req_valid = 0;
    endtask

    task automatic get(output logic w, output logic e, output logic [7:0] r);
        int n = 0;
        while (!resp_valid && n < 100) begin @(negedge clk); n++; end
        if (!resp_valid) chk("resp_timeout", 0, 1);
        w = resp_write; e = resp_err; r = resp_rdata;
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while ((expq.size() != 0 || resp_valid) && n < 2000) begin @(negedge clk); n++; end
        chk("drain_empty", expq.size(), 0);
    endtask

    typedef struct {
        logic w; logic [15:0] a; logic [7:0] d;
        logic e_err; logic [7:0] e_rd; int e_wr_cyc; int e_rd_cyc;
    } vec_t;
    vec_t tbl [10];

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic rw, re;
        logic [7:0] rd;
        int w0, r0, n0, e;
        for (int i = 0; i < 2048; i++) begin sram[i] = 0; ref_mem[i] = 0; end
        tbl[0] = '{1, 16'h1005, 8'hA5, 0, 8'h00, 2, 0};
        tbl[1] = '{0, 16'h1005, 8'h00, 0, 8'hA5, 0, 2};
        tbl[2] = '{0, 16'h0FFF, 8'h00, 1, 8'h00, 0, 0};
        tbl[3] = '{0, 16'h1800, 8'h00, 1, 8'h00, 0, 0};
        tbl[4] = '{1, 16'h17FF, 8'h3C, 0, 8'h00, 2, 0};
        tbl[5] = '{0, 16'h17FF, 8'h00, 0, 8'h3C, 0, 2};
        tbl[6] = '{1, 16'h1000, 8'h5A, 0, 8'h00, 2, 0};
        tbl[7] = '{0, 16'h1000, 8'h00, 0, 8'h5A, 0, 2};
        tbl[8] = '{1, 16'h0FFF, 8'h77, 1, 8'h00, 0, 0};
        tbl[9] = '{0, 16'hFFFF, 8'h00, 1, 8'h00, 0, 0};
        reset_n = 0; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_enables", {cpu_read_en, cpu_write_en}, 0);
        chk("rst_fifo_count", fifo_count, 0);
        chk("rst_cpu_addr", cpu_addr, 0);
        reset_n = 1;
        // Vector table: one transaction per entry, enable widths from one wait state.
        wr_ws = 1; rd_ws = 1;
        for (int i = 0; i < 10; i++) begin
            w0 = wr_hi; r0 = rd_hi;
            send(tbl[i].w, tbl[i].a, tbl[i].d);
            get(rw, re, rd);
            chk($sformatf("tbl%0d_write", i), rw, tbl[i].w);
            chk($sformatf("tbl%0d_err", i), re, tbl[i].e_err);
            chk($sformatf("tbl%0d_rdata", i), rd, tbl[i].e_rd);
            chk($sformatf("tbl%0d_wr_cyc", i), wr_hi - w0, tbl[i].e_wr_cyc);
            chk($sformatf("tbl%0d_rd_cyc", i), rd_hi - r0, tbl[i].e_rd_cyc);
        end
        // Latency: write ready in first ISSUE cycle, read one wait state later.
        wr_ws = 0; rd_ws = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 1; req_write = (k == 0); req_addr = 16'h1005; req_wdata = 8'hC3;
            @(posedge clk); #1 req_valid = 0;
            e = 0;
            while (!resp_valid && e < 50) begin @(posedge clk); #1; e++; end
            chk(k == 0 ? "lat_write" : "lat_read", e, k == 0 ? 3 : 4);
            @(negedge clk);
        end
        // Backpressure: stalled consumer fills the FIFO; order preserved on release.
        for (int i = 0; i < 6; i++) begin send(1, 16'h1200 + 16'(i), 8'h10 + 8'(i)); get(rw, re, rd); end
        n0 = nresp;
        rr_fixed = 0;
        for (int i = 0; i < 5; i++) send(0, 16'h1200 + 16'(i), 0);
        repeat (30) @(negedge clk);
        chk("bp_fifo_count", fifo_count, 4);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_resp_held", {resp_valid, resp_rdata}, {1'b1, 8'h10});
        rr_fixed = 1;
        send(0, 16'h1205, 0);
        drain();
        chk("bp_resp_count", nresp - n0, 6);
        // Timeout with a controller that never answers.
        stub = 1; r0 = rd_hi;
        send(0, 16'h1010, 0);
        get(rw, re, rd);
        chk("to_resp", {rw, re, rd}, {1'b0, 1'b1, 8'h00});
        chk("to_rd_cycles", rd_hi - r0, TO);
        chk("to_enable_low", cpu_read_en, 0);
        // Reset while a read is in ISSUE with another queued.
        send(0, 16'h1020, 0);
        send(0, 16'h1021, 0);
        chk("rstm_issuing", {cpu_read_en, fifo_count}, {1'b1, 3'd1});
        reset_n = 0; #1;
        chk("rstm_rd_en", cpu_read_en, 0);
        chk("rstm_fifo_count", fifo_count, 0);
        chk("rstm_resp_valid", resp_valid, 0);
        chk("rstm_req_ready", req_ready, 1);
        @(negedge clk); reset_n = 1; stub = 0; n0 = nresp;
        repeat (30) @(negedge clk);
        chk("rstm_no_resp", nresp - n0, 0);
        // Randomized traffic against the reference model.
        wr_ws = int'($urandom_range(0, 2)); rd_ws = int'($urandom_range(0, 2));
        rr_mode = 1;
        for (int i = 0; i < 200; i++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'(BASE + $urandom_range(0, 15));
            send(1'($urandom_range(0, 1)), a, 8'($urandom));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        rr_mode = 0;
        drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
